t_vals_gen: RTL and testbench

T_VALS_GEN -- requirements
Module: t_vals_gen

---
 rtl/phi_pkg.sv | 18 +
 rtl/lag_mac.sv | 64 ++++++
 rtl/t_vals_gen.sv | 161 ++++++++++++++++
 tb/tb_t_vals_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phi_pkg.sv
// Shared defaults and FSM state type for the T-value autocorrelation generator.
package phi_pkg;

  localparam int BIT_WIDTH    = 32;
  localparam int SAMPLE_WIDTH = 16;
  localparam int I            = 160;
  localparam int FORMANTS     = 5;
  localparam int NU_VALUES    = 3;
  localparam int PROD_SHIFT   = 8;
  localparam int BOUND_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/lag_mac.sv
// One lag of the autocorrelation: x[n]*x[n-L], arithmetic shift, accumulate.
// TVALS_SATURATE_EN selects saturating accumulation instead of modulo wrap.
module lag_mac #(
  parameter int BIT_WIDTH    = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int PROD_SHIFT   = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           en_i,
  input  logic signed [SAMPLE_WIDTH-1:0] x_i,
  input  logic signed [SAMPLE_WIDTH-1:0] x_lag_i,
  output logic signed [BIT_WIDTH-1:0]    acc_next_o
);

  localparam int PROD_W = 2 * SAMPLE_WIDTH;

  logic signed [PROD_W-1:0]    prod;
  logic signed [PROD_W-1:0]    prod_sh;
  logic signed [BIT_WIDTH-1:0] p_ext;
  logic signed [BIT_WIDTH-1:0] base;
  logic signed [BIT_WIDTH-1:0] acc_q;
  logic signed [BIT_WIDTH-1:0] acc_d;

  assign prod    = x_i * x_lag_i;
  assign prod_sh = prod >>> PROD_SHIFT;
  assign p_ext   = BIT_WIDTH'(prod_sh);
  // A frame restart may accept its first sample in the same cycle, so clear feeds the adder.
  assign base    = clear_i ? '0 : acc_q;

`ifdef TVALS_SATURATE_EN
  localparam logic signed [BIT_WIDTH-1:0] ACC_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH-1:0] ACC_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic signed [BIT_WIDTH:0] sum_ext;

  assign sum_ext = {base[BIT_WIDTH-1], base} + {p_ext[BIT_WIDTH-1], p_ext};

  always_comb begin
    acc_d = base;
    if (en_i) begin
      if (sum_ext[BIT_WIDTH] != sum_ext[BIT_WIDTH-1]) begin
        acc_d = sum_ext[BIT_WIDTH] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum_ext[BIT_WIDTH-1:0];
      end
    end
  end
`else
  assign acc_d = en_i ? (base + p_ext) : base;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/t_vals_gen.sv
// Per-frame lag-0..2 autocorrelation with FORMANTS segment strobes of cumulative sums.
// Optional macro TVALS_SATURATE_EN makes the accumulators saturate (see lag_mac).
module t_vals_gen #(
  parameter int BIT_WIDTH    = phi_pkg::BIT_WIDTH,
  parameter int SAMPLE_WIDTH = phi_pkg::SAMPLE_WIDTH,
  parameter int I            = phi_pkg::I,
  parameter int FORMANTS     = phi_pkg::FORMANTS,
  parameter int NU_VALUES    = phi_pkg::NU_VALUES,
  parameter int PROD_SHIFT   = phi_pkg::PROD_SHIFT
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid,
  input  logic                           frame_start,
  input  logic [7:0]                     boundary_0,
  input  logic [7:0]                     boundary_1,
  input  logic [7:0]                     boundary_2,
  input  logic [7:0]                     boundary_3,
  input  logic [7:0]                     boundary_4,
  output logic                           output_start,
  output logic                           output_valid,
  output logic [BIT_WIDTH-1:0]           T_vals_0,
  output logic [BIT_WIDTH-1:0]           T_vals_1,
  output logic [BIT_WIDTH-1:0]           T_vals_2,
  output logic                           busy
);

  import phi_pkg::*;

  localparam int K_W = $clog2(FORMANTS + 1);
  localparam logic [7:0]     LAST_N = 8'(I - 1);
  localparam logic [7:0]     N_ONE  = 8'd1;
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_DONE = K_W'(FORMANTS);

  state_t                        state_q, state_d;
  logic [7:0]                    n_q, n_d, n_cur;
  logic [K_W-1:0]                k_q, k_d, k_cur;
  logic [7:0]                    bnd_q [FORMANTS];
  logic [7:0]                    bnd_d [FORMANTS];
  logic [7:0]                    bnd_in [FORMANTS];
  logic [7:0]                    bnd_sel;
  logic signed [SAMPLE_WIDTH-1:0] hist_q [1:NU_VALUES-1];
  logic signed [SAMPLE_WIDTH-1:0] hist_d [1:NU_VALUES-1];
  logic signed [SAMPLE_WIDTH-1:0] lag_x [NU_VALUES];
  logic signed [BIT_WIDTH-1:0]   acc_d [NU_VALUES];
  logic signed [BIT_WIDTH-1:0]   tv_q [NU_VALUES];
  logic                          accept, strobe;
  logic                          start_q, valid_q;

  assign bnd_in[0] = boundary_0;
  assign bnd_in[1] = boundary_1;
  assign bnd_in[2] = boundary_2;
  assign bnd_in[3] = boundary_3;
  assign bnd_in[4] = boundary_4;

  assign accept = sample_valid && (frame_start || (state_q == ACCUM));

  always_comb begin
    bnd_sel = '0;
    for (int j = 0; j < FORMANTS; j++) begin
      if (k_q == K_W'(j)) bnd_sel = bnd_q[j];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NU_VALUES; gi++) begin : g_lag
      // History is forced to zero while a new frame begins.
      if (gi == 0) begin : g_cur
        assign lag_x[gi] = sample_in;
      end else begin : g_hist
        assign lag_x[gi] = frame_start ? '0 : hist_q[gi];
      end

      lag_mac #(
        .BIT_WIDTH   (BIT_WIDTH),
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .PROD_SHIFT  (PROD_SHIFT)
      ) u_mac (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .clear_i   (frame_start),
        .en_i      (accept),
        .x_i       (sample_in),
        .x_lag_i   (lag_x[gi]),
        .acc_next_o(acc_d[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    bnd_d   = bnd_q;
    hist_d  = hist_q;
    n_cur   = n_q;
    k_cur   = k_q;
    strobe  = 1'b0;

    if (frame_start) begin
      state_d = ACCUM;
      n_cur   = '0;
      k_cur   = '0;
      n_d     = '0;
      k_d     = '0;
      bnd_d   = bnd_in;
      for (int j = 1; j < NU_VALUES; j++) hist_d[j] = '0;
    end

    if (accept) begin
      hist_d[1] = sample_in;
      for (int j = 2; j < NU_VALUES; j++) hist_d[j] = frame_start ? '0 : hist_q[j-1];
      n_d = n_cur + N_ONE;
      // Index 0 never matches, so a strobe cannot land on the output_start cycle.
      if ((n_cur != '0) && (k_cur != K_DONE) && (n_cur == bnd_sel)) begin
        strobe = 1'b1;
        k_d    = k_cur + K_ONE;
      end
      if (n_cur == LAST_N) state_d = (k_d == K_DONE) ? IDLE : FLUSH;
    end else if ((state_q == FLUSH) && !frame_start) begin
      strobe = 1'b1;
      k_d    = k_q + K_ONE;
      if (k_d == K_DONE) state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      for (int j = 0; j < FORMANTS; j++) bnd_q[j] <= '0;
      for (int j = 1; j < NU_VALUES; j++) hist_q[j] <= '0;
      for (int j = 0; j < NU_VALUES; j++) tv_q[j] <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      bnd_q   <= bnd_d;
      hist_q  <= hist_d;
      start_q <= frame_start;
      valid_q <= strobe;
      if (strobe) begin
        for (int j = 0; j < NU_VALUES; j++) tv_q[j] <= acc_d[j];
      end
    end
  end

  assign output_start = start_q;
  assign output_valid = valid_q;
  assign T_vals_0     = tv_q[0];
  assign T_vals_1     = tv_q[1];
  assign T_vals_2     = tv_q[2];
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_t_vals_gen.sv
// Scoreboard bench for t_vals_gen: a behavioural model pushes expected strobes,
// the per-cycle monitor pops and compares them; scenario tasks add direct checks.
module tb_t_vals_gen;

  logic               clk = 1'b0;
  logic               rst, sv, fs;
  logic signed [15:0] smp;
  logic [7:0]         bd0, bd1, bd2, bd3, bd4;
  logic               os, ov, busy;
  logic [31:0]        t0, t1, t2;

  logic               s_rst, s_sv, s_fs;
  logic signed [15:0] s_smp;
  logic [7:0]         s_bd0, s_bdx;
  logic               s_os, s_ov, s_busy;
  logic [31:0]        s_t0, s_t1, s_t2;

  always #5 clk = ~clk;

  t_vals_gen dut (
    .clk_in(clk), .rst_in(rst), .sample_in(smp), .sample_valid(sv), .frame_start(fs),
    .boundary_0(bd0), .boundary_1(bd1), .boundary_2(bd2), .boundary_3(bd3), .boundary_4(bd4),
    .output_start(os), .output_valid(ov), .T_vals_0(t0), .T_vals_1(t1), .T_vals_2(t2), .busy(busy)
  );

  t_vals_gen #(.PROD_SHIFT(0)) u_sat (
    .clk_in(clk), .rst_in(s_rst), .sample_in(s_smp), .sample_valid(s_sv), .frame_start(s_fs),
    .boundary_0(s_bd0), .boundary_1(s_bdx), .boundary_2(s_bdx), .boundary_3(s_bdx), .boundary_4(s_bdx),
    .output_start(s_os), .output_valid(s_ov), .T_vals_0(s_t0), .T_vals_1(s_t1), .T_vals_2(s_t2), .busy(s_busy)
  );

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  exp_t   exp_q[$];
  int     cap_t0[$], cap_t1[$], cap_t2[$], cap_cyc[$];
  int     n_starts, start_cyc, s_strobes, last_edge;

  bit     m_act;
  int     m_n, m_k, m_x1, m_x2;
  int     m_b[5];
  longint m_acc[3];

  function automatic longint acc_add(longint a, longint p);
    longint s;
    s = a + p;
`ifdef TVALS_SATURATE_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
`else
    return longint'($signed(s[31:0]));
`endif
  endfunction

  task automatic model_start(input int b0, b1, b2, b3, b4);
    m_act = 1'b1; m_n = 0; m_k = 0; m_x1 = 0; m_x2 = 0;
    m_b[0] = b0; m_b[1] = b1; m_b[2] = b2; m_b[3] = b3; m_b[4] = b4;
    for (int j = 0; j < 3; j++) m_acc[j] = 0;
    exp_q.delete();
  endtask

  task automatic model_push();
    exp_t e;
    e.v0 = m_acc[0][31:0];
    e.v1 = m_acc[1][31:0];
    e.v2 = m_acc[2][31:0];
    exp_q.push_back(e);
    m_k++;
  endtask

  task automatic model_sample(input int x);
    if (!m_act) return;
    m_acc[0] = acc_add(m_acc[0], longint'((x * x) >>> 8));
    m_acc[1] = acc_add(m_acc[1], longint'((x * m_x1) >>> 8));
    m_acc[2] = acc_add(m_acc[2], longint'((x * m_x2) >>> 8));
    m_x2 = m_x1;
    m_x1 = x;
    if (m_n != 0 && m_k < 5 && m_n == m_b[m_k]) model_push();
    if (m_n == 159) begin
      while (m_k < 5) model_push();
      m_act = 1'b0;
    end
    m_n++;
  endtask

  // Observes both DUTs 1 time unit after every rising edge.
  task automatic monitor();
    exp_t e;
    if (os) begin
      n_starts++;
      start_cyc = cyc;
      checks++;
      if (ov) begin
        errors++;
        $display("FAIL start_valid_overlap: output_valid=%0b required 0 at cycle %0d", ov, cyc);
      end
    end
    if (ov) begin
      cap_t0.push_back($signed(t0));
      cap_t1.push_back($signed(t1));
      cap_t2.push_back($signed(t2));
      cap_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got T=%0d/%0d/%0d with no strobe expected (cycle %0d)",
                 $signed(t0), $signed(t1), $signed(t2), cyc);
      end else begin
        e = exp_q.pop_front();
        if ({t0, t1, t2} !== {e.v0, e.v1, e.v2}) begin
          errors++;
          $display("FAIL strobe_values: got T=%0d/%0d/%0d required %0d/%0d/%0d (cycle %0d)",
                   $signed(t0), $signed(t1), $signed(t2),
                   $signed(e.v0), $signed(e.v1), $signed(e.v2), cyc);
        end
      end
    end
    if (s_ov) s_strobes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic clear_caps();
    cap_t0.delete(); cap_t1.delete(); cap_t2.delete(); cap_cyc.delete();
    n_starts = 0;
  endtask

  task automatic start_frame(input int b0, b1, b2, b3, b4, input bit with_s, input int x);
    fs = 1'b1;
    bd0 = b0[7:0]; bd1 = b1[7:0]; bd2 = b2[7:0]; bd3 = b3[7:0]; bd4 = b4[7:0];
    model_start(b0, b1, b2, b3, b4);
    if (with_s) begin
      sv = 1'b1;
      smp = x[15:0];
      model_sample(x);
    end
    last_edge = cyc + 1;
    tick();
    fs = 1'b0;
    sv = 1'b0;
  endtask

  task automatic send(input int x);
    sv = 1'b1;
    smp = x[15:0];
    model_sample(x);
    last_edge = cyc + 1;
    tick();
    sv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
    $display("check %s: got %0d required %0d", name, got, req);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_val("reset_T0", $signed(t0), 0);
    check_val("reset_T1", $signed(t1), 0);
    check_val("reset_T2", $signed(t2), 0);
    check_val("reset_valid", int'(ov), 0);
    check_val("reset_start", int'(os), 0);
    check_val("reset_busy", int'(busy), 0);
  endtask

  task automatic test_constant();
    int fs_edge;
    clear_caps();
    start_frame(31, 63, 95, 127, 159, 1'b0, 0);
    fs_edge = last_edge;
    check_val("const_busy_in_frame", int'(busy), 1);
    for (int i = 0; i < 160; i++) send(256);
    idle(3);
    check_val("const_starts", n_starts, 1);
    check_val("const_start_cycle", start_cyc, fs_edge);
    check_val("const_strobes", cap_t0.size(), 5);
    check_val("const_first_T0", cap_t0[0], 8192);
    check_val("const_first_T1", cap_t1[0], 7936);
    check_val("const_first_T2", cap_t2[0], 7680);
    check_val("const_last_T0", cap_t0[4], 40960);
    check_val("const_last_T1", cap_t1[4], 40704);
    check_val("const_last_T2", cap_t2[4], 40448);
    check_val("const_busy_after", int'(busy), 0);
    check_val("const_queue_drained", exp_q.size(), 0);
  endtask

  task automatic test_alternating();
    clear_caps();
    start_frame(9, 20, 40, 80, 120, 1'b0, 0);
    for (int i = 0; i < 160; i++) send((i % 2 == 0) ? 256 : -256);
    idle(3);
    check_val("alt_strobes", cap_t0.size(), 5);
    check_val("alt_T0", cap_t0[0], 2560);
    check_val("alt_T1", cap_t1[0], -2304);
    check_val("alt_T2", cap_t2[0], 2048);
  endtask

  task automatic test_flush();
    logic signed [15:0] r;
    clear_caps();
    start_frame(10, 10, 10, 10, 10, 1'b0, 0);
    for (int i = 0; i < 160; i++) begin
      r = 16'($urandom);
      send(int'(r));
    end
    idle(6);
    check_val("flush_strobes", cap_t0.size(), 5);
    check_val("flush_first_after_last", cap_cyc[1], last_edge + 1);
    for (int j = 2; j < 5; j++) check_val($sformatf("flush_consecutive_%0d", j), cap_cyc[j], cap_cyc[1] + j - 1);
    check_val("flush_busy_after", int'(busy), 0);
    check_val("flush_queue_drained", exp_q.size(), 0);
  endtask

  task automatic test_restart();
    logic signed [15:0] r;
    int fs_edge;
    start_frame(31, 63, 95, 127, 159, 1'b0, 0);
    for (int i = 0; i <= 50; i++) begin
      r = 16'($urandom);
      send(int'(r));
    end
    clear_caps();
    start_frame(20, 40, 60, 80, 100, 1'b1, 1000);
    fs_edge = last_edge;
    for (int i = 1; i < 160; i++) begin
      r = 16'($urandom);
      send(int'(r));
    end
    idle(3);
    check_val("restart_starts", n_starts, 1);
    check_val("restart_start_cycle", start_cyc, fs_edge);
    check_val("restart_strobes", cap_t0.size(), 5);
    check_val("restart_queue_drained", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] r;
    start_frame(20, 40, 60, 70, 150, 1'b0, 0);
    for (int i = 0; i < 70; i++) begin
      r = 16'($urandom_range(200, 30000));
      send(int'(r));
    end
    sv = 1'b1;
    smp = 16'sd1234;
    rst = 1'b1;
    m_act = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    sv = 1'b0;
    check_val("midrst_T0", $signed(t0), 0);
    check_val("midrst_T1", $signed(t1), 0);
    check_val("midrst_T2", $signed(t2), 0);
    check_val("midrst_valid", int'(ov), 0);
    check_val("midrst_busy", int'(busy), 0);
    clear_caps();
    for (int i = 0; i < 30; i++) send(300);
    idle(4);
    check_val("midrst_no_strobes", cap_t0.size(), 0);
    check_val("midrst_no_starts", n_starts, 0);
  endtask

  task automatic test_saturate();
    int t0_req;
`ifdef TVALS_SATURATE_EN
    t0_req = 2147483647;
`else
    t0_req = -1073938429;
`endif
    s_strobes = 0;
    s_fs = 1'b1;
    tick();
    s_fs = 1'b0;
    s_smp = 16'sd32767;
    s_sv = 1'b1;
    idle(3);
    check_val("sat_valid", int'(s_ov), 1);
    check_val("sat_T0", $signed(s_t0), t0_req);
    check_val("sat_T1", $signed(s_t1), 2147352578);
    idle(157);
    s_sv = 1'b0;
    idle(6);
    check_val("sat_total_strobes", s_strobes, 5);
    check_val("sat_busy_after", int'(s_busy), 0);
  endtask

  initial begin
    rst = 1'b1; sv = 1'b0; fs = 1'b0; smp = '0;
    bd0 = '0; bd1 = '0; bd2 = '0; bd3 = '0; bd4 = '0;
    s_rst = 1'b1; s_sv = 1'b0; s_fs = 1'b0; s_smp = '0;
    s_bd0 = 8'd2; s_bdx = 8'd200;
    n_starts = 0; start_cyc = -1; s_strobes = 0; last_edge = 0;
    m_act = 1'b0;
    idle(2);
    s_rst = 1'b0;
    test_reset();
    test_constant();
    test_alternating();
    test_flush();
    test_restart();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
